// File: rtl/spi_slave_fe.sv
// rtl/spi_slave_fe.sv - SPI slave front end: MOSI deserialiser, MISO serialiser, frame FSM
module spi_slave_fe #(
    parameter int ADDR_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 SS_n,
    input  logic                 MOSI,
    output logic                 MISO,
    output logic [ADDR_SIZE+1:0] rx_data,
    output logic                 rx_valid,
    input  logic [ADDR_SIZE-1:0] tx_data,
    input  logic                 tx_valid
);
    localparam int W   = ADDR_SIZE + 2;
    localparam int CW  = $clog2(W);
    localparam int TCW = $clog2(ADDR_SIZE + 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHK_CMD   = 3'd1,
        WRITE     = 3'd2,
        READ_ADD  = 3'd3,
        READ_DATA = 3'd4
    } state_t;

    state_t                 state;
    state_t                 next_state;
    logic [CW-1:0]          bit_cnt;
    logic [W-2:0]           shift_reg;
    logic                   word_done;
    logic                   rd_addr_done;
    logic [ADDR_SIZE-1:0]   tx_shift;
    logic [TCW-1:0]         tx_cnt;
    logic                   tx_busy;
    logic                   tx_done;

    logic                   abort;
    logic                   sample_bit;
    logic                   last_bit;
    logic                   load_tx;
    logic                   shift_tx;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: the first frame bit picks the command path, SS_n high aborts
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (!SS_n) next_state = CHK_CMD;
            end
            CHK_CMD: begin
                if (SS_n)               next_state = IDLE;
                else if (!MOSI)         next_state = WRITE;
                else if (!rd_addr_done) next_state = READ_ADD;
                else                    next_state = READ_DATA;
            end
            WRITE, READ_ADD, READ_DATA: begin
                if (SS_n) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Control strobes for the datapath, derived from state and frame progress
    always_comb begin
        abort      = SS_n && (state != IDLE);
        sample_bit = 1'b0;
        load_tx    = 1'b0;
        shift_tx   = 1'b0;
        if (!SS_n) begin
            case (state)
                CHK_CMD: sample_bit = 1'b1;
                WRITE, READ_ADD: sample_bit = !word_done;
                READ_DATA: begin
                    sample_bit = !word_done;
                    load_tx    = word_done && !tx_busy && !tx_done && tx_valid;
                    shift_tx   = tx_busy;
                end
                default: sample_bit = 1'b0;
            endcase
        end
        // CHK_CMD always sees bit_cnt == 0, so only a data state can finish the word
        last_bit = sample_bit && (bit_cnt == CW'(W - 1));
    end

    // Datapath: shift in MOSI, hand over the word, serialise the RAM read word on MISO
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt      <= '0;
            shift_reg    <= '0;
            word_done    <= 1'b0;
            rd_addr_done <= 1'b0;
            tx_shift     <= '0;
            tx_cnt       <= '0;
            tx_busy      <= 1'b0;
            tx_done      <= 1'b0;
            MISO         <= 1'b0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (state == IDLE || abort) begin
                // Partial words are dropped; rd_addr_done survives so a read can resume
                bit_cnt   <= '0;
                word_done <= 1'b0;
                tx_cnt    <= '0;
                tx_busy   <= 1'b0;
                tx_done   <= 1'b0;
                MISO      <= 1'b0;
            end else begin
                if (sample_bit) begin
                    shift_reg <= {shift_reg[W-3:0], MOSI};
                    if (last_bit) begin
                        rx_data   <= {shift_reg, MOSI};
                        rx_valid  <= 1'b1;
                        word_done <= 1'b1;
                        if (state == READ_ADD) rd_addr_done <= 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt + CW'(1);
                    end
                end
                if (load_tx) begin
                    tx_shift     <= {tx_data[ADDR_SIZE-2:0], 1'b0};
                    MISO         <= tx_data[ADDR_SIZE-1];
                    tx_cnt       <= TCW'(1);
                    tx_busy      <= 1'b1;
                    rd_addr_done <= 1'b0;
                end else if (shift_tx) begin
                    if (tx_cnt == TCW'(ADDR_SIZE)) begin
                        MISO    <= 1'b0;
                        tx_busy <= 1'b0;
                        tx_done <= 1'b1;
                    end else begin
                        MISO     <= tx_shift[ADDR_SIZE-1];
                        tx_shift <= {tx_shift[ADDR_SIZE-2:0], 1'b0};
                        tx_cnt   <= tx_cnt + TCW'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_fe.sv
// tb/tb_spi_slave_fe.sv - randomized self-checking bench for spi_slave_fe
module tb_spi_slave_fe;
    localparam int AS = 8;
    localparam int W  = AS + 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          SS_n;
    logic          MOSI;
    logic          MISO;
    logic [W-1:0]  rx_data;
    logic          rx_valid;
    logic [AS-1:0] tx_data;
    logic          tx_valid;

    int            n_checks = 0;
    int            n_pass   = 0;
    int            rx_cnt   = 0;
    logic [W-1:0]  last_rx  = '0;
    bit            m_rd_done = 1'b0;

    spi_slave_fe #(.ADDR_SIZE(AS)) dut (
        .clk      (clk),
        .rst      (rst),
        .SS_n     (SS_n),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rx_valid === 1'b1) begin
            rx_cnt++;
            last_rx = rx_data;
        end
    endtask

    // abort_pos: -1 full frame; 0..W-1 SS_n rises after that many bits; W rises with the last bit
    task automatic run_frame(input logic [W-1:0] word, input int abort_pos, input bit skip_tx,
                             input logic [AS-1:0] d, input int ld);
        int         rx_before;
        bit         is_rd_data;
        bit         is_rd_add;
        logic       miso_seen;
        logic [11:0] got_miso;
        logic [11:0] exp_miso;
        rx_before  = rx_cnt;
        is_rd_data = word[W-1] && m_rd_done;
        is_rd_add  = word[W-1] && !m_rd_done;
        miso_seen  = 1'b0;
        SS_n = 1'b0;
        MOSI = 1'($urandom_range(0, 1));
        tick();
        miso_seen |= MISO;
        for (int i = 0; i < W; i++) begin
            if (abort_pos >= 0 && abort_pos < W && i == abort_pos) break;
            MOSI = word[W-1-i];
            if (abort_pos == W && i == W - 1) SS_n = 1'b1;
            tick();
            miso_seen |= MISO;
        end
        if (abort_pos >= 0) begin
            SS_n = 1'b1;
            tick();
            check_eq("abort_miso", 32'(miso_seen | MISO), 32'd0);
            tick();
            check_eq("abort_no_rx", 32'(rx_cnt - rx_before), 32'd0);
            return;
        end
        check_eq("rx_pulses", 32'(rx_cnt - rx_before), 32'd1);
        check_eq("rx_word", 32'(last_rx), 32'(word));
        check_eq("frame_miso", 32'(miso_seen), 32'd0);
        if (is_rd_add) m_rd_done = 1'b1;
        got_miso = '0;
        for (int j = 0; j < 12; j++) begin
            MOSI     = 1'($urandom_range(0, 1));
            tx_valid = !skip_tx && (j == ld || j == ld + 3 || j == ld + 9);
            tx_data  = (j == ld) ? d : ~d;
            tick();
            got_miso[j] = MISO;
            tx_valid = 1'b0;
        end
        for (int j = 0; j < 12; j++)
            exp_miso[j] = (is_rd_data && !skip_tx && j >= ld && j < ld + AS) ? d[AS-1-(j-ld)] : 1'b0;
        check_eq("miso_seq", 32'(got_miso), 32'(exp_miso));
        check_eq("one_word", 32'(rx_cnt - rx_before), 32'd1);
        if (is_rd_data && !skip_tx) m_rd_done = 1'b0;
        SS_n = 1'b1;
        tick();
        check_eq("miso_end", 32'(MISO), 32'd0);
        tick();
    endtask

    initial begin
        rst = 1'b1; SS_n = 1'b1; MOSI = 1'b0; tx_data = '0; tx_valid = 1'b0;
        tick();
        tick();
        check_eq("rst_miso", 32'(MISO), 32'd0);
        check_eq("rst_rx_valid", 32'(rx_valid), 32'd0);
        check_eq("rst_rx_data", 32'(rx_data), 32'd0);
        rst = 1'b0;
        m_rd_done = 1'b0;
        tick();

        run_frame(10'h05A, -1, 1'b0, 8'hA5, 1);
        run_frame(10'h1C3, -1, 1'b0, 8'h3C, 0);
        run_frame(10'h205, -1, 1'b0, 8'h77, 1);
        run_frame(10'h300, -1, 1'b0, 8'hC3, 2);
        run_frame(10'h3FF, -1, 1'b0, 8'hFF, 0);
        run_frame(10'h0F0, 4, 1'b0, 8'h00, 0);
        run_frame(10'h001, -1, 1'b0, 8'h81, 1);
        run_frame(10'h155, W, 1'b0, 8'h00, 0);
        run_frame(10'h2AA, 0, 1'b0, 8'h00, 0);

        for (int k = 0; k < 40; k++) begin
            logic [W-1:0]  w;
            logic [AS-1:0] d;
            int            ap;
            w  = W'($urandom);
            d  = AS'($urandom);
            ap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, W)) : -1;
            run_frame(w, ap, ($urandom_range(0, 3) == 0), d, int'($urandom_range(0, 2)));
        end

        // reset mid-frame
        SS_n = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            MOSI = 1'b1;
            tick();
        end
        rst = 1'b1; SS_n = 1'b1;
        tick();
        check_eq("t6a_rx_valid", 32'(rx_valid), 32'd0);
        check_eq("t6a_rx_data", 32'(rx_data), 32'd0);
        check_eq("t6a_miso", 32'(MISO), 32'd0);
        rst = 1'b0;
        m_rd_done = 1'b0;
        tick();
        run_frame(10'h0AB, -1, 1'b0, 8'h12, 0);

        // reset mid-MISO shift
        run_frame(10'h2AA, -1, 1'b0, 8'h00, 0);
        SS_n = 1'b0;
        tick();
        for (int i = 0; i < W; i++) begin
            MOSI = (i == 0 || i == 1);
            tick();
        end
        tx_valid = 1'b1; tx_data = 8'hFF;
        tick();
        tx_valid = 1'b0;
        check_eq("t6b_shift", 32'(MISO), 32'd1);
        tick();
        tick();
        rst = 1'b1; SS_n = 1'b1;
        tick();
        check_eq("t6b_miso", 32'(MISO), 32'd0);
        check_eq("t6b_rx_valid", 32'(rx_valid), 32'd0);
        check_eq("t6b_rx_data", 32'(rx_data), 32'd0);
        rst = 1'b0;
        m_rd_done = 1'b0;
        tick();
        run_frame(10'h3FF, -1, 1'b0, 8'hFF, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
